mix_col_engine: RTL and testbench

- Multi-cycle, parametrised AES MixColumns / InvMixColumns engine for the cipher datapath. It sits between the ShiftRows and AddRoundKey stages.
- Accepts a full state of STATE_COLS 32-bit columns in one transfer. It processes LANES columns per cycle through shared column mixers, selected forward or inverse per transfer.
- It returns the mixed state through a valid/ready output handshake.
- Successor to the fixed single-column combinational inverse mixer. It adds forward/inverse mode, width and parallelism parameters, and flow control.

---
 rtl/mix_col_engine.sv | 170 +++++++++++++++++
 tb/tb_mix_col_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_col_engine.sv
// mix_col_engine -- multi-cycle AES MixColumns / InvMixColumns engine.
//
// Accepts a full cipher state of STATE_COLS 32-bit columns in one handshake.
// It mixes LANES columns per cycle in place in a work register, then presents
// the result until the downstream takes it. Forward or inverse mode is chosen
// per transfer. The inverse reuses the forward mixer and adds a small
// correction term built from the same xtime chain.
//
// Parameters:
//   STATE_COLS  columns per state (4, 6 or 8)
//   LANES       columns mixed per cycle; must divide STATE_COLS
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   in_valid   input state offered
//   in_ready   engine can accept a state (IDLE only)
//   in_inv     0 = MixColumns, 1 = InvMixColumns, sampled on accept
//   in_skip    (only with MIXCOL_SKIP_EN) pass the state through unmixed
//   in_state   state, column 0 in the MSBs, row 0 in bits [31:24] of a column
//   out_valid  result available (DONE)
//   out_ready  downstream accepts the result
//   out_state  mixed state, same layout as in_state
//   busy       high while columns are being mixed
//
// Optional feature macro: MIXCOL_SKIP_EN adds in_skip. When it is set on
// accept, the state goes IDLE->DONE unchanged (final AES round).

module mix_col_engine #(
   parameter int STATE_COLS = 4,
   parameter int LANES      = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_inv,
`ifdef MIXCOL_SKIP_EN
   input  logic                    in_skip,
`endif
   input  logic [32*STATE_COLS-1:0] in_state,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [32*STATE_COLS-1:0] out_state,
   output logic                    busy
);

   localparam int GROUPS = STATE_COLS / LANES;
   localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IDX_W  = $clog2(STATE_COLS);
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             mode;
   logic [31:0]      work [STATE_COLS];
   logic [IDX_W-1:0] lane_col [LANES];
   logic [31:0]      lane_mix [LANES];
   logic             accept;
   logic             skip_req;

   // GF(2^8) multiply by 2, reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column. The forward row r is b[r] ^ t ^ 2*(b[r]^b[r+1]), with t the
   // XOR of all four bytes. The inverse adds 0C*p ^ 08*q on rows 0/2 and
   // 08*p ^ 0C*q on rows 1/3, where p = b0^b2 and q = b1^b3.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] b [4];
      logic [7:0] r [4];
      logic [7:0] t, p4, p8, q4, q8, c02, c13;
      for (int i = 0; i < 4; i++) b[i] = col[31-8*i -: 8];
      t = b[0] ^ b[1] ^ b[2] ^ b[3];
      for (int i = 0; i < 4; i++) r[i] = b[i] ^ t ^ xtime(b[i] ^ b[(i+1)%4]);
      p4  = xtime(xtime(b[0] ^ b[2]));
      p8  = xtime(p4);
      q4  = xtime(xtime(b[1] ^ b[3]));
      q8  = xtime(q4);
      c02 = p8 ^ p4 ^ q8;
      c13 = p8 ^ q8 ^ q4;
      if (inv) begin
         r[0] = r[0] ^ c02;
         r[2] = r[2] ^ c02;
         r[1] = r[1] ^ c13;
         r[3] = r[3] ^ c13;
      end
      return {r[0], r[1], r[2], r[3]};
   endfunction

`ifdef MIXCOL_SKIP_EN
   assign skip_req = in_skip;
`else
   assign skip_req = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   // The columns touched this cycle are cnt*LANES .. cnt*LANES+LANES-1.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_col[l] = IDX_W'(int'(cnt) * LANES + l);
         lane_mix[l] = mix_col(work[lane_col[l]], mode);
      end
   end

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output and the next state get a default before the case, so
   // no path through this block can leave a signal unassigned (no latches).
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = skip_req ? DONE : BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == LAST_GRP) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the work array is reset on purpose. It drives out_state directly,
   // and out_state has to read zero after reset, so this is not a plain RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         mode <= 1'b0;
         for (int c = 0; c < STATE_COLS; c++) work[c] <= '0;
      end else if (accept) begin
         cnt  <= '0;
         mode <= in_inv;
         for (int c = 0; c < STATE_COLS; c++) work[c] <= in_state[32*(STATE_COLS-1-c) +: 32];
      end else if (busy) begin
         for (int l = 0; l < LANES; l++) work[lane_col[l]] <= lane_mix[l];
         cnt <= cnt + 1'b1;
      end
   end

   // The work register is only loaded in IDLE and mixed in BUSY, so it is
   // stable for the whole of DONE.
   always_comb begin
      out_state = '0;
      for (int c = 0; c < STATE_COLS; c++) out_state[32*(STATE_COLS-1-c) +: 32] = work[c];
   end

endmodule

// File: tb/tb_mix_col_engine.sv
// Self-checking bench for mix_col_engine.
// It drives three instances: defaults (4 cols / 1 lane), LANES=4, and
// STATE_COLS=8 / LANES=2. Directed vectors use hand-computed constants. The
// random sweep uses a GF(2^8) reference built on generic multiplication with
// the textbook coefficient matrices.
// Define MIXCOL_SKIP_EN for both files to exercise the pass-through port.

module tb_mix_col_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  iv;
   logic [2:0]  invv;
   logic [2:0]  ordy;
   logic [2:0]  sk;
   logic [127:0] ist0, ist1;
   logic [255:0] ist2;
   wire  [2:0]  ir, ov, bsy;
   wire  [127:0] ost0, ost1;
   wire  [255:0] ost2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mix_col_engine u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_inv(invv[0]),
`ifdef MIXCOL_SKIP_EN
      .in_skip(sk[0]),
`endif
      .in_state(ist0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost0), .busy(bsy[0])
   );

   mix_col_engine #(.STATE_COLS(4), .LANES(4)) u_l4 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_inv(invv[1]),
`ifdef MIXCOL_SKIP_EN
      .in_skip(sk[1]),
`endif
      .in_state(ist1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost1), .busy(bsy[1])
   );

   mix_col_engine #(.STATE_COLS(8), .LANES(2)) u_c8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_inv(invv[2]),
`ifdef MIXCOL_SKIP_EN
      .in_skip(sk[2]),
`endif
      .in_state(ist2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost2), .busy(bsy[2])
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] col_ref(input logic [31:0] col, input logic inv);
      logic [7:0] cf [4];
      logic [7:0] b [4];
      logic [7:0] o;
      logic [31:0] res;
      if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int i = 0; i < 4; i++) b[i] = col[31-8*i -: 8];
      res = '0;
      for (int r = 0; r < 4; r++) begin
         o = 8'h00;
         for (int k = 0; k < 4; k++) o = o ^ gmul(cf[k], b[(r+k)%4]);
         res[31-8*r -: 8] = o;
      end
      return res;
   endfunction

   function automatic logic [255:0] state_ref(input logic [255:0] st, input int ncols, input logic inv);
      logic [255:0] res;
      res = '0;
      for (int c = 0; c < ncols; c++) res[32*(ncols-1-c) +: 32] = col_ref(st[32*(ncols-1-c) +: 32], inv);
      return res;
   endfunction

   // ---------------- drivers ----------------
   function automatic logic [255:0] get_ost(input int d);
      case (d)
         0:       return {128'h0, ost0};
         1:       return {128'h0, ost1};
         default: return ost2;
      endcase
   endfunction

   task automatic drive(input int d, input logic [255:0] st, input logic inv, input logic skp);
      case (d)
         0:       ist0 = st[127:0];
         1:       ist1 = st[127:0];
         default: ist2 = st;
      endcase
      invv[d] = inv;
      sk[d]   = skp;
   endtask

   // One full transfer with out_ready held high. Inputs are scrambled right
   // after the accept edge. lat counts edges from the accept edge, starting
   // at 1, up to the first edge after which out_valid is seen.
   task automatic xfer(input int d, input logic [255:0] st, input logic inv, input logic skp,
                       output logic [255:0] res, output int lat);
      @(negedge clk);
      check($sformatf("ready_pre%0d", d), {255'h0, ir[d]}, 256'h1);
      drive(d, st, inv, skp);
      iv[d]   = 1'b1;
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      drive(d, ~st, ~inv, 1'b0);
      lat = 1;
      while (!ov[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = get_ost(d);
      @(posedge clk); #1;
      check($sformatf("valid_drop%0d", d), {255'h0, ov[d]}, 256'h0);
   endtask

   logic [255:0] v_fwd_in, v_fwd_out, res, st, exp_v;
   logic [31:0]  sc_in  [3];
   logic [31:0]  sc_out [3];
   int lat, bad, seen;

   initial begin
      rst  = 1'b1;
      iv   = '0;
      invv = '0;
      ordy = '0;
      sk   = '0;
      ist0 = '0;
      ist1 = '0;
      ist2 = '0;
      v_fwd_in  = {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
      v_fwd_out = {32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
      sc_in[0] = 32'hdb135345; sc_out[0] = 32'h8e4da1bc;
      sc_in[1] = 32'hf20a225c; sc_out[1] = 32'h9fdc589d;
      sc_in[2] = 32'h01010101; sc_out[2] = 32'h01010101;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {255'h0, ir[0]},  256'h1);
      check("rst_out_valid", {255'h0, ov[0]},  256'h0);
      check("rst_busy",      {255'h0, bsy[0]}, 256'h0);
      check("rst_out_state", get_ost(0),       256'h0);
      @(negedge clk);
      rst = 1'b0;

      // forward FIPS-197 column set, then inverse round trip
      xfer(0, v_fwd_in, 1'b0, 1'b0, res, lat);
      check("fwd_state", res, v_fwd_out);
      check("fwd_lat", 256'(lat), 256'd5);
      xfer(0, v_fwd_out, 1'b1, 1'b0, res, lat);
      check("inv_state", res, v_fwd_in);
      check("inv_lat", 256'(lat), 256'd5);

      // single-column vectors replicated across all four columns
      for (int i = 0; i < 3; i++) begin
         xfer(0, {128'h0, {4{sc_in[i]}}}, 1'b0, 1'b0, res, lat);
         check($sformatf("col_fwd%0d", i), res, {128'h0, {4{sc_out[i]}}});
         xfer(0, {128'h0, {4{sc_out[i]}}}, 1'b1, 1'b0, res, lat);
         check($sformatf("col_inv%0d", i), res, {128'h0, {4{sc_in[i]}}});
      end

      // backpressure: result held 10 cycles while a second state is offered
      @(negedge clk);
      drive(0, v_fwd_in, 1'b0, 1'b0);
      iv[0]   = 1'b1;
      ordy[0] = 1'b0;
      @(posedge clk); #1;
      drive(0, v_fwd_out, 1'b1, 1'b0);
      lat = 1;
      while (!ov[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_lat", 256'(lat), 256'd5);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (get_ost(0) !== {128'h0, v_fwd_out} || ir[0] !== 1'b0 || ov[0] !== 1'b1) bad++;
      end
      check("bp_stable_cycles", 256'(bad), 256'd0);
      @(negedge clk);
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_drain_valid", {255'h0, ov[0]},  256'h0);
      check("bp_drain_ready", {255'h0, ir[0]},  256'h1);
      check("bp_not_taken",   {255'h0, bsy[0]}, 256'h0);

      // reset during the second BUSY cycle
      @(negedge clk);
      drive(0, v_fwd_in, 1'b0, 1'b0);
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      check("mid_busy", {255'h0, bsy[0]}, 256'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_ready", {255'h0, ir[0]}, 256'h1);
      check("mid_rst_valid", {255'h0, ov[0]}, 256'h0);
      check("mid_rst_state", get_ost(0),      256'h0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ov[0]) seen++;
      end
      check("mid_rst_no_stale", 256'(seen), 256'd0);

`ifdef MIXCOL_SKIP_EN
      xfer(0, v_fwd_in, 1'b0, 1'b1, res, lat);
      check("skip_state", res, v_fwd_in);
      check("skip_lat", 256'(lat), 256'd1);
      xfer(2, {v_fwd_out, v_fwd_in[127:0]}, 1'b1, 1'b1, res, lat);
      check("skip_state_c8", res, {v_fwd_out, v_fwd_in[127:0]});
      check("skip_lat_c8", 256'(lat), 256'd1);
`endif

      // parameter sweep against the reference model, both modes
      for (int i = 0; i < 4; i++) begin
         st = {128'h0, $urandom, $urandom, $urandom, $urandom};
         exp_v = state_ref(st, 4, i[0]);
         xfer(1, st, i[0], 1'b0, res, lat);
         check($sformatf("l4_state%0d", i), res, exp_v);
         check($sformatf("l4_lat%0d", i), 256'(lat), 256'd2);
         st = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         exp_v = state_ref(st, 8, i[0]);
         xfer(2, st, i[0], 1'b0, res, lat);
         check($sformatf("c8_state%0d", i), res, exp_v);
         check($sformatf("c8_lat%0d", i), 256'(lat), 256'd5);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
